// File: rtl/board_state.sv
// board_state: connect-four board with height tracking, falling-piece animation and move legality.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   col_sel    - target column 0..6 (7 is illegal)
//   drop       - move request, sampled only while idle
//   clear      - synchronous new-game request
//   red_enc    - red occupancy incl. falling overlay, bit = col + 7*row (row 0 top)
//   yellow_enc - yellow occupancy, same indexing
//   turn       - player to move, 0 red / 1 yellow
//   busy       - a move is falling or landing
//   move_done  - one-cycle pulse in the landing cycle
//   illegal    - one-cycle pulse after a rejected drop
//   board_full - registered, all 42 cells occupied
module board_state #(
    parameter int FALL_TICKS = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  col_sel,
    input  logic        drop,
    input  logic        clear,
    output logic [41:0] red_enc,
    output logic [41:0] yellow_enc,
    output logic        turn,
    output logic        busy,
    output logic        move_done,
    output logic        illegal,
    output logic        board_full
);
    typedef enum logic [1:0] {IDLE, FALL, LAND} state_t;
    localparam int TW = FALL_TICKS > 1 ? $clog2(FALL_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(FALL_TICKS - 1);
    state_t          state_q, state_d;
    // entry 7 is never written; it lets col_sel=7 index safely
    logic [7:0][2:0] height_q, height_d;
    logic [2:0]      col_q, col_d, row_q, row_d, land_row;
    logic [TW-1:0]   tick_q, tick_d;
    logic [41:0]     red_q, red_d, yellow_q, yellow_d, cur_bit, overlay;
    logic [5:0]      cur_idx;
    logic            turn_q, turn_d, illegal_q, illegal_d, full_q, full_d, legal;
    always_comb begin
        land_row  = 3'd5 - height_q[col_q];
        cur_idx   = {3'b0, col_q} + 6'd7 * {3'b0, row_q};
        cur_bit   = 42'd1 << cur_idx;
        legal     = col_sel != 3'd7 && height_q[col_sel] != 3'd6;
        state_d   = state_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        tick_d    = tick_q;
        red_d     = red_q;
        yellow_d  = yellow_q;
        turn_d    = turn_q;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (drop && legal) begin
                    col_d   = col_sel;
                    row_d   = 3'd0;
                    tick_d  = '0;
                    state_d = FALL;
                end
                illegal_d = drop && !legal;
            end
            FALL: begin
                tick_d = tick_q + 1'b1;
                if (tick_q == TICK_LAST) begin
                    if (row_q == land_row) begin
                        // commit on entry so the piece is solid during the LAND cycle
                        state_d  = LAND;
                        red_d    = turn_q ? red_q : red_q | cur_bit;
                        yellow_d = turn_q ? yellow_q | cur_bit : yellow_q;
                    end else begin
                        row_d  = row_q + 3'd1;
                        tick_d = '0;
                    end
                end
            end
            LAND: begin
                height_d[col_q] = height_q[col_q] + 3'd1;
                turn_d          = ~turn_q;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d   = IDLE;
            height_d  = '0;
            col_d     = 3'd0;
            row_d     = 3'd0;
            tick_d    = '0;
            red_d     = '0;
            yellow_d  = '0;
            turn_d    = 1'b0;
            illegal_d = 1'b0;
        end
        full_d = 1'b1;
        for (int c = 0; c < 7; c++) full_d = full_d && height_d[c] == 3'd6;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            height_q  <= '0;
            col_q     <= 3'd0;
            row_q     <= 3'd0;
            tick_q    <= '0;
            red_q     <= '0;
            yellow_q  <= '0;
            turn_q    <= 1'b0;
            illegal_q <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            height_q  <= height_d;
            col_q     <= col_d;
            row_q     <= row_d;
            tick_q    <= tick_d;
            red_q     <= red_d;
            yellow_q  <= yellow_d;
            turn_q    <= turn_d;
            illegal_q <= illegal_d;
            full_q    <= full_d;
        end
    end
    always_comb begin
        overlay    = state_q == FALL ? cur_bit : '0;
        red_enc    = red_q | (turn_q ? '0 : overlay);
        yellow_enc = yellow_q | (turn_q ? overlay : '0);
        turn       = turn_q;
        busy       = state_q != IDLE;
        move_done  = state_q == LAND;
        illegal    = illegal_q;
        board_full = full_q;
    end
endmodule

// File: tb/tb_board_state.sv
// tb_board_state: directed self-checking bench for board_state with FALL_TICKS=2.
module tb_board_state;
    logic        clk = 1'b0;
    logic        rst_n, drop, clear, turn, busy, move_done, illegal, board_full;
    logic [2:0]  col_sel;
    logic [41:0] red_enc, yellow_enc;
    int          n_cmp = 0, n_bad = 0;
    board_state #(.FALL_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .col_sel(col_sel), .drop(drop), .clear(clear),
        .red_enc(red_enc), .yellow_enc(yellow_enc), .turn(turn), .busy(busy),
        .move_done(move_done), .illegal(illegal), .board_full(board_full)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // issue one drop, then wait (bounded) for move_done and check its latency
    task automatic do_move(input logic [2:0] c, input int exp_lat);
        int k;
        @(negedge clk);
        col_sel = c;
        drop    = 1'b1;
        @(negedge clk);
        drop = 1'b0;
        k    = 1;
        while (!move_done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("move_latency", 64'(k), 64'(exp_lat));
    endtask
    task automatic count_done(input int cycles, output int md, output int il);
        md = 0;
        il = 0;
        repeat (cycles) begin
            @(negedge clk);
            md += int'(move_done);
            il += int'(illegal);
        end
    endtask
    initial begin
        int md, il;
        logic [41:0] r_exp, y_exp;
        rst_n = 1'b1; drop = 1'b0; clear = 1'b0; col_sel = 3'd0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_red", 64'(red_enc), 0);
        chk("reset_yellow", 64'(yellow_enc), 0);
        chk("reset_flags", 64'({busy, turn, move_done, illegal, board_full}), 0);
        rst_n = 1'b1;
        // single drop into column 3 with full animation trace
        @(negedge clk);
        col_sel = 3'd3;
        drop    = 1'b1;
        @(negedge clk);
        drop = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk("fall_red", 64'(red_enc), 64'd1 << (3 + 7 * ((c - 1) / 2)));
            chk("fall_busy_done", 64'({busy, move_done, yellow_enc == 42'd0}), 3'b101);
            @(negedge clk);
        end
        chk("land_done", 64'(move_done), 1);
        chk("land_red", 64'(red_enc), 64'd1 << 38);
        @(negedge clk);
        chk("after_land", 64'({move_done, busy, turn}), 3'b001);
        chk("after_red", 64'(red_enc), 64'd1 << 38);
        // new game, then stack column 0
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_idle", 64'({red_enc, yellow_enc, turn, busy}), 0);
        for (int i = 0; i < 6; i++) do_move(3'd0, (6 - i) * 2 + 1);
        r_exp = (42'd1 << 35) | (42'd1 << 21) | (42'd1 << 7);
        y_exp = (42'd1 << 28) | (42'd1 << 14) | 42'd1;
        @(negedge clk);
        col_sel = 3'd0;
        drop    = 1'b1;
        @(negedge clk);
        drop = 1'b0;
        chk("col_full_illegal", 64'({illegal, busy}), 2'b10);
        @(negedge clk);
        chk("col_full_pulse_end", 64'(illegal), 0);
        chk("col0_red", 64'(red_enc), 64'(r_exp));
        chk("col0_yellow", 64'(yellow_enc), 64'(y_exp));
        chk("col0_turn", 64'(turn), 0);
        // column 7 is illegal
        col_sel = 3'd7;
        drop    = 1'b1;
        @(negedge clk);
        drop = 1'b0;
        chk("col7_illegal", 64'({illegal, busy}), 2'b10);
        @(negedge clk);
        chk("col7_pulse_end", 64'({illegal, busy, turn}), 0);
        chk("col7_enc", 64'({red_enc ^ r_exp, yellow_enc ^ y_exp}), 0);
        // drop toggling during FALL is ignored
        col_sel = 3'd1;
        drop    = 1'b1;
        @(negedge clk);
        col_sel = 3'd7;
        md      = 0;
        il      = 0;
        for (int c = 1; c <= 11; c++) begin
            drop = ~drop;
            @(negedge clk);
            md += int'(move_done);
            il += int'(illegal);
        end
        drop = 1'b0;
        count_done(10, md, il);
        chk("toggle_done", 64'(md), 1);
        chk("toggle_illegal", 64'(il), 0);
        chk("toggle_red", 64'(red_enc), 64'(r_exp | (42'd1 << 36)));
        chk("toggle_turn", 64'(turn), 1);
        // clear three cycles into FALL
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        col_sel = 3'd2;
        drop    = 1'b1;
        @(negedge clk);
        drop = 1'b0;
        chk("pre_clear_overlay", 64'(red_enc), 64'd1 << 2);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("midfall_clear", 64'({red_enc, yellow_enc, busy, turn, move_done}), 0);
        count_done(15, md, il);
        chk("midfall_clear_no_done", 64'(md), 0);
        // asynchronous reset three cycles into FALL
        col_sel = 3'd2;
        drop    = 1'b1;
        @(negedge clk);
        drop = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 64'({red_enc, yellow_enc, busy, turn, move_done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(15, md, il);
        chk("async_no_done", 64'(md), 0);
        chk("async_enc", 64'({red_enc, yellow_enc}), 0);
        // fill the whole board
        for (int c = 0; c < 7; c++)
            for (int i = 0; i < 6; i++) begin
                do_move(3'(c), (6 - i) * 2 + 1);
                if (c == 6 && i == 5) chk("full_at_last_done", 64'(board_full), 0);
            end
        @(negedge clk);
        chk("board_full", 64'(board_full), 1);
        chk("full_union", 64'(red_enc | yellow_enc), 64'({42{1'b1}}));
        chk("full_disjoint", 64'(red_enc & yellow_enc), 0);
        chk("full_turn", 64'(turn), 0);
        col_sel = 3'd3;
        drop    = 1'b1;
        @(negedge clk);
        chk("full_drop_illegal", 64'({illegal, busy}), 2'b10);
        drop = 1'b0;
        @(negedge clk);
        chk("full_pulse_end", 64'({illegal, busy, board_full}), 3'b001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
